// File: rtl/mc_controller.sv
// Multicycle control FSM for the RV32I core: sequences the shared ALU, register file
// and unified memory, with a memory-ready stall, a wait timeout and a sticky trap state.
module mc_controller #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       trap,
    output logic [3:0] state
);

    localparam int unsigned CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] A_ADD  = 4'b0000;
    localparam logic [3:0] A_SUB  = 4'b0001;
    localparam logic [3:0] A_AND  = 4'b0010;
    localparam logic [3:0] A_OR   = 4'b0011;
    localparam logic [3:0] A_XOR  = 4'b0100;
    localparam logic [3:0] A_SLT  = 4'b0101;
    localparam logic [3:0] A_SLTU = 4'b0110;
    localparam logic [3:0] A_SLL  = 4'b0111;
    localparam logic [3:0] A_SRL  = 4'b1000;
    localparam logic [3:0] A_SRA  = 4'b1001;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        JALRLINK = 4'd12,
        UPPER    = 4'd13,
        TRAP     = 4'd14
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = A_ADD;
        trap       = 1'b0;
        state      = state_q;

        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECR;
                    OP_I:              state_d = EXECI;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI, OP_AUIPC:  state_d = UPPER;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = opcode[5] ? 3'b001 : 3'b000;
                state_d = opcode[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = (state_q == EXECI) ? 2'b01 : 2'b00;
                state_d = ALUWB;
                case (funct3)
                    3'b000:  ALUControl = (state_q == EXECR && funct7b5) ? A_SUB : A_ADD;
                    3'b001:  ALUControl = A_SLL;
                    3'b010:  ALUControl = A_SLT;
                    3'b011:  ALUControl = A_SLTU;
                    3'b100:  ALUControl = A_XOR;
                    3'b101:  ALUControl = funct7b5 ? A_SRA : A_SRL;
                    3'b110:  ALUControl = A_OR;
                    default: ALUControl = A_AND;
                endcase
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                state_d = FETCH;
                // funct3[0] selects taken-on-Zero vs taken-on-!Zero, inverted for beq/bne
                case (funct3)
                    3'b000: begin ALUControl = A_SUB;  PCWrite = Zero;  end
                    3'b001: begin ALUControl = A_SUB;  PCWrite = !Zero; end
                    3'b100: begin ALUControl = A_SLT;  PCWrite = !Zero; end
                    3'b101: begin ALUControl = A_SLT;  PCWrite = Zero;  end
                    3'b110: begin ALUControl = A_SLTU; PCWrite = !Zero; end
                    3'b111: begin ALUControl = A_SLTU; PCWrite = Zero;  end
                    default: state_d = TRAP;
                endcase
            end
            JAL, JALRLINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = JALRLINK;
            end
            UPPER: begin
                ImmSrc = 3'b100;
                if (opcode[5]) begin
                    ResultSrc = 2'b11;
                    RegWrite  = 1'b1;
                    state_d   = FETCH;
                end else begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    state_d = ALUWB;
                end
            end
            TRAP: trap = 1'b1;
            default: state_d = TRAP;
        endcase

        // The counter tops out one short of the limit; the stall that would reach it traps instead.
        if (mem_req && !mem_ready) begin
            if (WAIT_LIMIT != 0 && wait_q == LIMIT_M1) state_d = TRAP;
            else wait_d = wait_q + 1'b1;
        end

        if (!reset) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ImmSrc     = 3'b000;
            ALUControl = 4'b0000;
            trap       = 1'b0;
            state      = 4'b0000;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-instruction vector table plus reset, stall,
// trap and wait-timeout sequences.
module tb_mc_controller;

    typedef struct packed {
        logic       mr, mw, adr, irw, pcw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       tr;
    } ctrl_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [3:0]  st3;
        ctrl_t       c3;
        int unsigned len;
    } vec_t;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7, S_BRANCH = 4'd9;
    localparam logic [3:0] S_JAL = 4'd10, S_JALR = 4'd11, S_UPPER = 4'd13, S_TRAP = 4'd14;

    logic clk = 1'b0;
    logic reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic funct7b5, Zero, mem_ready, mem_ready2;

    logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl, state;

    logic mem_req2, MemWrite2, AdrSrc2, IRWrite2, PCWrite2, RegWrite2, trap2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2;
    logic [2:0] ImmSrc2;
    logic [3:0] ALUControl2, state2;

    ctrl_t act, act2;
    assign act  = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
                   ALUSrcB, ImmSrc, ALUControl, trap};
    assign act2 = {mem_req2, MemWrite2, AdrSrc2, IRWrite2, PCWrite2, RegWrite2, ResultSrc2,
                   ALUSrcA2, ALUSrcB2, ImmSrc2, ALUControl2, trap2};

    mc_controller #(.WAIT_LIMIT(255)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .trap(trap), .state(state)
    );

    mc_controller #(.WAIT_LIMIT(4)) dut_w4 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready2), .mem_req(mem_req2), .MemWrite(MemWrite2),
        .AdrSrc(AdrSrc2), .IRWrite(IRWrite2), .PCWrite(PCWrite2), .RegWrite(RegWrite2),
        .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2),
        .ALUControl(ALUControl2), .trap(trap2), .state(state2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic ctrl_t ctl(input logic mr, mw, adr, irw, pcw, rw,
                                  input logic [1:0] rs, sa, sb, input logic [2:0] imm,
                                  input logic [3:0] alu, input logic tr);
        return {mr, mw, adr, irw, pcw, rw, rs, sa, sb, imm, alu, tr};
    endfunction

    function automatic vec_t mkv(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic [3:0] st3, input ctrl_t c3,
                                 input int unsigned len);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.st3 = st3; v.c3 = c3; v.len = len;
        return v;
    endfunction

    function automatic ctrl_t e_r(input logic [3:0] alu);
        return ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0);
    endfunction
    function automatic ctrl_t e_i(input logic [3:0] alu);
        return ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, alu, 0);
    endfunction
    function automatic ctrl_t e_b(input logic [3:0] alu, input logic pcw);
        return ctl(0, 0, 0, 0, pcw, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t vecs[24];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int stall, nreq, nrw, cyc;
        ctrl_t fetch_exp;
        fetch_exp = ctl(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 0);

        vecs[0]  = mkv(7'b0110011, 3'b000, 0, 0, S_EXECR, e_r(4'b0000), 4);
        vecs[1]  = mkv(7'b0110011, 3'b000, 1, 0, S_EXECR, e_r(4'b0001), 4);
        vecs[2]  = mkv(7'b0110011, 3'b001, 0, 0, S_EXECR, e_r(4'b0111), 4);
        vecs[3]  = mkv(7'b0110011, 3'b011, 0, 0, S_EXECR, e_r(4'b0110), 4);
        vecs[4]  = mkv(7'b0110011, 3'b101, 1, 0, S_EXECR, e_r(4'b1001), 4);
        vecs[5]  = mkv(7'b0110011, 3'b110, 0, 0, S_EXECR, e_r(4'b0011), 4);
        vecs[6]  = mkv(7'b0010011, 3'b000, 1, 0, S_EXECI, e_i(4'b0000), 4);
        vecs[7]  = mkv(7'b0010011, 3'b010, 0, 0, S_EXECI, e_i(4'b0101), 4);
        vecs[8]  = mkv(7'b0010011, 3'b100, 0, 0, S_EXECI, e_i(4'b0100), 4);
        vecs[9]  = mkv(7'b0010011, 3'b101, 0, 0, S_EXECI, e_i(4'b1000), 4);
        vecs[10] = mkv(7'b0010011, 3'b111, 0, 0, S_EXECI, e_i(4'b0010), 4);
        vecs[11] = mkv(7'b0000011, 3'b010, 0, 0, S_MEMADR,
                       ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 0), 5);
        vecs[12] = mkv(7'b0100011, 3'b010, 0, 0, S_MEMADR,
                       ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 0), 4);
        vecs[13] = mkv(7'b1100011, 3'b000, 0, 1, S_BRANCH, e_b(4'b0001, 1), 3);
        vecs[14] = mkv(7'b1100011, 3'b001, 0, 0, S_BRANCH, e_b(4'b0001, 1), 3);
        vecs[15] = mkv(7'b1100011, 3'b001, 0, 1, S_BRANCH, e_b(4'b0001, 0), 3);
        vecs[16] = mkv(7'b1100011, 3'b100, 0, 0, S_BRANCH, e_b(4'b0101, 1), 3);
        vecs[17] = mkv(7'b1100011, 3'b101, 0, 0, S_BRANCH, e_b(4'b0101, 0), 3);
        vecs[18] = mkv(7'b1100011, 3'b110, 0, 1, S_BRANCH, e_b(4'b0110, 0), 3);
        vecs[19] = mkv(7'b1100011, 3'b111, 0, 1, S_BRANCH, e_b(4'b0110, 1), 3);
        vecs[20] = mkv(7'b1101111, 3'b000, 0, 0, S_JAL,
                       ctl(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 0), 4);
        vecs[21] = mkv(7'b1100111, 3'b000, 0, 0, S_JALR,
                       ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 0), 5);
        vecs[22] = mkv(7'b0110111, 3'b000, 0, 0, S_UPPER,
                       ctl(0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b100, 4'b0000, 0), 3);
        vecs[23] = mkv(7'b0010111, 3'b000, 0, 0, S_UPPER,
                       ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b100, 4'b0000, 0), 4);

        reset = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        mem_ready = 1'b1; mem_ready2 = 1'b0;

        // Reset holds every output low even with mem_ready high
        repeat (2) @(negedge clk);
        #1;
        chk("reset outputs", 32'(act), 32'd0);
        chk("reset state", 32'(state), 32'(S_FETCH));
        chk("reset outputs w4", 32'(act2), 32'd0);

        // Timeout: WAIT_LIMIT=4 instance never sees mem_ready
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            chk($sformatf("w4 stall%0d state", k), 32'(state2), 32'(S_FETCH));
            chk($sformatf("w4 stall%0d req/strobes", k),
                32'({mem_req2, IRWrite2, PCWrite2, trap2}), 32'(4'b1000));
        end
        @(negedge clk); #1;
        chk("w4 trap", 32'({trap2, mem_req2, IRWrite2, PCWrite2}), 32'(4'b1000));
        chk("w4 trap state", 32'(state2), 32'(S_TRAP));

        // Per-instruction vectors with mem_ready tied high
        for (int i = 0; i < 24; i++) begin
            do_reset();
            opcode = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7; Zero = vecs[i].z;
            mem_ready = 1'b1;
            #1;
            chk($sformatf("v%0d fetch state", i), 32'(state), 32'(S_FETCH));
            chk($sformatf("v%0d fetch ctrl", i), 32'(act), 32'(fetch_exp));
            @(negedge clk); #1;
            chk($sformatf("v%0d decode state", i), 32'(state), 32'(S_DECODE));
            chk($sformatf("v%0d decode ctrl", i), 32'(act),
                32'(ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01,
                        (vecs[i].op == 7'b1101111) ? 3'b011 : 3'b010, 4'b0000, 0)));
            @(negedge clk); #1;
            chk($sformatf("v%0d exec state", i), 32'(state), 32'(vecs[i].st3));
            chk($sformatf("v%0d exec ctrl", i), 32'(act), 32'(vecs[i].c3));
            n = 3;
            while (n < 12) begin
                @(negedge clk); #1;
                if (state == S_FETCH) break;
                n++;
            end
            chk($sformatf("v%0d latency", i), n, vecs[i].len);
        end

        // Reset mid-MEMWRITE aborts the store
        do_reset();
        opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("store memwrite state", 32'(state), 32'(S_MEMWRITE));
        chk("store memwrite ctrl", 32'(act),
            32'(ctl(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0)));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort outputs", 32'(act), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort release state", 32'(state), 32'(S_FETCH));
        chk("abort release req/we", 32'({mem_req, MemWrite}), 32'(2'b10));

        // Load with three stall cycles in MEMREAD
        do_reset();
        opcode = 7'b0000011; funct3 = 3'b010;
        stall = 0; nreq = 0; nrw = 0; cyc = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = !(state == S_MEMREAD && stall < 3);
            if (!mem_ready) stall++;
            #1;
            if (mem_req && AdrSrc) nreq++;
            if (RegWrite) begin
                nrw++;
                chk("load memwb resultsrc", 32'(ResultSrc), 32'(2'b01));
            end
            cyc = i;
            if (i > 0 && state == S_FETCH) break;
        end
        chk("load req cycles", nreq, 4);
        chk("load regwrite count", nrw, 1);
        chk("load total cycles", cyc, 8);

        // Reserved branch funct3 traps without redirecting
        do_reset();
        opcode = 7'b1100011; funct3 = 3'b010; Zero = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("br010 pcwrite", 32'({state, PCWrite}), 32'({S_BRANCH, 1'b0}));
        @(negedge clk); #1;
        chk("br010 trap", 32'({state, trap}), 32'({S_TRAP, 1'b1}));

        // Illegal opcode: absorbing trap until reset
        do_reset();
        opcode = 7'b1111111; mem_ready = 1'b1;
        @(negedge clk); #1;
        chk("illegal decode", 32'(state), 32'(S_DECODE));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk($sformatf("illegal trap%0d", k), 32'({trap, mem_req, state}),
                32'({1'b1, 1'b0, S_TRAP}));
            chk($sformatf("illegal strobes%0d", k), 32'(act),
                32'(ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1)));
        end
        do_reset();
        #1;
        chk("trap cleared", 32'({trap, state}), 32'({1'b0, S_FETCH}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
